// File: rtl/cache_pkg.sv
// Shared cache geometry, line-controller state encoding and address helpers.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned LINE_BYTES = LINE_WORDS * DATA_BYTES;
  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} line_ctrl_state_e;

  typedef logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] cache_line_t;

  // Clears the byte offset within a line.
  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
  endfunction

  // Byte address of word idx within the line at base; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [IDX_W-1:0]      idx);
    return base + (ADDR_WIDTH'(idx) << $clog2(DATA_BYTES));
  endfunction

endpackage

// File: rtl/cache_line_mem_ctrl.sv
// Miss/eviction sequencer: optional dirty-line write-back, then a line fill
// of LINE_WORDS single-word reads with overlapped address and data channels.
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high; a valid source holds its payload stable until that edge.
module cache_line_mem_ctrl
  import cache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_dirty_i,
  input  logic [ADDR_WIDTH-1:0] victim_addr_i,
  input  cache_line_t           victim_line_i,
  output logic                  fill_valid_o,
  output logic [IDX_W-1:0]      fill_idx_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  done_o,
  output logic                  wb_valid_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  input  logic                  mem_ready_i,
  output logic                  addr_req_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic                  addr_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  output line_ctrl_state_e      state_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  line_ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0]      wb_cnt_q, wb_cnt_d;
  logic [IDX_W-1:0]      r_cnt_q, r_cnt_d;
  logic [IDX_W:0]        ar_cnt_q, ar_cnt_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] victim_addr_q, victim_addr_d;
  cache_line_t           line_q, line_d;

  always_comb begin
    state_d       = state_q;
    wb_cnt_d      = wb_cnt_q;
    r_cnt_d       = r_cnt_q;
    ar_cnt_d      = ar_cnt_q;
    req_addr_d    = req_addr_q;
    victim_addr_d = victim_addr_q;
    line_d        = line_q;
    req_ready_o   = 1'b0;
    fill_valid_o  = 1'b0;
    fill_idx_o    = '0;
    fill_data_o   = '0;
    done_o        = 1'b0;
    wb_valid_o    = 1'b0;
    wb_data_o     = '0;
    wb_addr_o     = '0;
    addr_req_o    = 1'b0;
    addr_o        = '0;
    mem_ready_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          req_addr_d    = line_align(req_addr_i);
          victim_addr_d = line_align(victim_addr_i);
          line_d        = victim_line_i;
          wb_cnt_d      = '0;
          r_cnt_d       = '0;
          ar_cnt_d      = '0;
          state_d       = req_dirty_i ? WB : RD;
        end
      end
      WB: begin
        wb_valid_o = 1'b1;
        wb_data_o  = line_q[wb_cnt_q];
        wb_addr_o  = word_addr(victim_addr_q, wb_cnt_q);
        if (mem_ready_i) begin
          wb_cnt_d = wb_cnt_q + 1'b1;
          if (wb_cnt_q == LAST_IDX) state_d = RD;
        end
      end
      RD: begin
        // MSB of ar_cnt set means all LINE_WORDS addresses have been issued.
        if (!ar_cnt_q[IDX_W]) begin
          addr_req_o = 1'b1;
          addr_o     = word_addr(req_addr_q, ar_cnt_q[IDX_W-1:0]);
          if (addr_ready_i) ar_cnt_d = ar_cnt_q + 1'b1;
        end
        mem_ready_o = 1'b1;
        if (mem_valid_i) begin
          fill_valid_o = 1'b1;
          fill_idx_o   = r_cnt_q;
          fill_data_o  = mem_data_i;
          r_cnt_d      = r_cnt_q + 1'b1;
          if (r_cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An aborted fill must not deliver words or signal completion.
    if (rst_i) begin
      fill_valid_o = 1'b0;
      done_o       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wb_cnt_q      <= '0;
      r_cnt_q       <= '0;
      ar_cnt_q      <= '0;
      req_addr_q    <= '0;
      victim_addr_q <= '0;
      line_q        <= '0;
    end else begin
      state_q       <= state_d;
      wb_cnt_q      <= wb_cnt_d;
      r_cnt_q       <= r_cnt_d;
      ar_cnt_q      <= ar_cnt_d;
      req_addr_q    <= req_addr_d;
      victim_addr_q <= victim_addr_d;
      line_q        <= line_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Bench for cache_line_mem_ctrl: the bench plays the cache core and the memory
// master, and checks every transfer against a per-miss list of expected transfers.
module tb_cache_line_mem_ctrl;
  import cache_pkg::*;

  logic                  clk;
  logic                  rst_i;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_dirty_i;
  logic [ADDR_WIDTH-1:0] victim_addr_i;
  cache_line_t           victim_line_i;
  logic                  fill_valid_o;
  logic [IDX_W-1:0]      fill_idx_o;
  logic [DATA_WIDTH-1:0] fill_data_o;
  logic                  done_o;
  logic                  wb_valid_o;
  logic [DATA_WIDTH-1:0] wb_data_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic                  mem_ready_i;
  logic                  addr_req_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  addr_ready_i;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic                  mem_valid_i;
  logic                  mem_ready_o;
  line_ctrl_state_e      state_o;

  cache_line_mem_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_dirty_i(req_dirty_i), .victim_addr_i(victim_addr_i), .victim_line_i(victim_line_i),
    .fill_valid_o(fill_valid_o), .fill_idx_o(fill_idx_o), .fill_data_o(fill_data_o),
    .done_o(done_o), .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_addr_o(wb_addr_o),
    .mem_ready_i(mem_ready_i), .addr_req_o(addr_req_o), .addr_o(addr_o),
    .addr_ready_i(addr_ready_i), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
    .mem_ready_o(mem_ready_o), .state_o(state_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard: expected write-backs {addr,data}, read addresses and fill words.
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] exp_wb_q[$];
  logic [ADDR_WIDTH-1:0]            exp_addr_q[$];
  logic [DATA_WIDTH-1:0]            exp_q[$];
  int                               exp_wb_total;
  // Read data the bench's master holds for accepted addresses, in issue order.
  logic [DATA_WIDTH-1:0]            rdq[$];

  function automatic logic [DATA_WIDTH-1:0] mem_fn(input logic [ADDR_WIDTH-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic load_model(input logic [ADDR_WIDTH-1:0] addr, input bit dirty,
                            input logic [ADDR_WIDTH-1:0] vaddr, input cache_line_t line);
    logic [ADDR_WIDTH-1:0] base, vbase, mask;
    mask  = ~32'd15;
    base  = addr & mask;
    vbase = vaddr & mask;
    exp_wb_q.delete();
    exp_addr_q.delete();
    exp_q.delete();
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (dirty) exp_wb_q.push_back({vbase + 32'(i * 4), line[i]});
      exp_addr_q.push_back(base + 32'(i * 4));
      exp_q.push_back(mem_fn(base + 32'(i * 4)));
    end
    exp_wb_total = dirty ? LINE_WORDS : 0;
  endtask

  // Driver: present one request and complete its handshake.
  task automatic accept(input logic [ADDR_WIDTH-1:0] addr, input bit dirty,
                        input logic [ADDR_WIDTH-1:0] vaddr, input cache_line_t line,
                        input bit hold, input logic [ADDR_WIDTH-1:0] next_addr);
    @(negedge clk);
    req_valid_i   = 1'b1;
    req_addr_i    = addr;
    req_dirty_i   = dirty;
    victim_addr_i = vaddr;
    victim_line_i = line;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b expected 1", req_ready_o);
    end
    load_model(addr, dirty, vaddr, line);
    @(posedge clk);
    #1;
    if (hold) begin
      req_addr_i  = next_addr;
      req_dirty_i = 1'b0;
    end else begin
      req_valid_i = 1'b0;
    end
  endtask

  // Act as master until done_o; rst_after >= 0 aborts with reset after that many fills.
  task automatic run_miss(input int stall_pct, input int rst_after, input bit b2b);
    int cyc = 0;
    bit first = 1'b1;
    bit done_seen = 1'b0;
    int wb_seen = 0;
    int fill_seen = 0;
    bit wb_stall = 1'b0;
    bit ar_stall = 1'b0;
    bit in_rd, exp_done;
    logic [ADDR_WIDTH-1:0] wb_a_prev, ar_prev;
    logic [DATA_WIDTH-1:0] wb_d_prev;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] e;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      mem_ready_i  = ($urandom_range(99) >= stall_pct);
      addr_ready_i = ($urandom_range(99) >= stall_pct);
      mem_valid_i  = (rdq.size() > 0) && ($urandom_range(99) >= stall_pct);
      mem_data_i   = (rdq.size() > 0) ? rdq[0] : $urandom;
      if (rst_after >= 0 && fill_seen == rst_after) begin
        rst_i       = 1'b1;
        mem_valid_i = 1'b1;
        #1;
        checks++;
        if (fill_valid_o !== 1'b0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL rst_cycle_quiet: fill_valid=%b done=%b expected 0 0", fill_valid_o, done_o);
        end
        @(posedge clk);
        #1;
        rst_i       = 1'b0;
        mem_valid_i = 1'b0;
        rdq.delete();
        #1;
        checks++;
        if (state_o !== IDLE || req_ready_o !== 1'b1 || done_o !== 1'b0 || addr_req_o !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid_idle: state=%0d ready=%b done=%b areq=%b expected 0 1 0 0",
                   state_o, req_ready_o, done_o, addr_req_o);
        end
        return;
      end
      #1;
      in_rd    = (exp_wb_q.size() == 0) && (fill_seen < LINE_WORDS);
      exp_done = (fill_seen == LINE_WORDS);
      if (first) begin
        checks++;
        if (wb_valid_o !== (exp_wb_total > 0) || addr_req_o !== (exp_wb_total == 0)) begin
          errors++;
          $display("FAIL first_cycle: wb_valid=%b addr_req=%b expected %b %b",
                   wb_valid_o, addr_req_o, exp_wb_total > 0, exp_wb_total == 0);
        end
      end
      checks++;
      if (req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready: got %b expected 0", req_ready_o);
      end
      // Write-back channel
      if (wb_stall) begin
        checks++;
        if (wb_valid_o !== 1'b1 || wb_addr_o !== wb_a_prev || wb_data_o !== wb_d_prev) begin
          errors++;
          $display("FAIL wb_hold: got %b %h %h expected 1 %h %h", wb_valid_o, wb_addr_o,
                   wb_data_o, wb_a_prev, wb_d_prev);
        end
      end
      checks++;
      if (wb_valid_o === 1'b1 && exp_wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_extra: got wb_valid=1 at %h expected no write-back", wb_addr_o);
      end
      if (wb_valid_o === 1'b1 && exp_wb_q.size() > 0 && mem_ready_i) begin
        e = exp_wb_q.pop_front();
        wb_seen++;
        checks++;
        if ({wb_addr_o, wb_data_o} !== e) begin
          errors++;
          $display("FAIL wb_word: got %h/%h expected %h/%h", wb_addr_o, wb_data_o,
                   e[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH], e[DATA_WIDTH-1:0]);
        end
      end
      wb_stall  = (wb_valid_o === 1'b1) && !mem_ready_i;
      wb_a_prev = wb_addr_o;
      wb_d_prev = wb_data_o;
      // Read address channel
      if (ar_stall) begin
        checks++;
        if (addr_req_o !== 1'b1 || addr_o !== ar_prev) begin
          errors++;
          $display("FAIL ar_hold: got %b %h expected 1 %h", addr_req_o, addr_o, ar_prev);
        end
      end
      if (addr_req_o === 1'b1) begin
        checks++;
        if (exp_wb_q.size() != 0 && !(wb_valid_o === 1'b1 && mem_ready_i && exp_wb_q.size() == 0)) begin
          errors++;
          $display("FAIL ar_before_wb: got addr_req=1 with %0d writes pending expected 0", exp_wb_q.size());
        end
        if (addr_ready_i) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL ar_extra: got %h expected no more addresses", addr_o);
          end else begin
            if (addr_o !== exp_addr_q[0]) begin
              errors++;
              $display("FAIL ar_addr: got %h expected %h", addr_o, exp_addr_q[0]);
            end
            void'(exp_addr_q.pop_front());
          end
          rdq.push_back(mem_fn(addr_o));
        end
      end
      ar_stall = (addr_req_o === 1'b1) && !addr_ready_i;
      ar_prev  = addr_o;
      // Read data channel
      checks++;
      if (mem_ready_o !== in_rd || fill_valid_o !== (mem_valid_i && in_rd)) begin
        errors++;
        $display("FAIL rd_flags: got mem_ready=%b fill_valid=%b expected %b %b",
                 mem_ready_o, fill_valid_o, in_rd, mem_valid_i && in_rd);
      end
      if (mem_valid_i && mem_ready_o === 1'b1) void'(rdq.pop_front());
      if (fill_valid_o === 1'b1 && in_rd) begin
        checks++;
        if (fill_idx_o !== IDX_W'(fill_seen) || fill_data_o !== exp_q[fill_seen]) begin
          errors++;
          $display("FAIL fill_word: got idx %0d data %h expected %0d %h", fill_idx_o,
                   fill_data_o, fill_seen, exp_q[fill_seen]);
        end
        fill_seen++;
      end
      checks++;
      if (done_o !== exp_done) begin
        errors++;
        $display("FAIL done_pulse: got %b expected %b", done_o, exp_done);
      end
      if (done_o === 1'b1 || exp_done) done_seen = 1'b1;
      @(posedge clk);
      cyc++;
      first = 1'b0;
    end
    mem_valid_i = 1'b0;
    checks++;
    if (!done_seen || wb_seen != exp_wb_total || fill_seen != LINE_WORDS) begin
      errors++;
      $display("FAIL miss_totals: got done=%b wb=%0d fills=%0d expected 1 %0d %0d",
               done_seen, wb_seen, fill_seen, exp_wb_total, LINE_WORDS);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || done_o !== 1'b0 || state_o !== IDLE) begin
      errors++;
      $display("FAIL after_done: got ready=%b done=%b state=%0d expected 1 0 0",
               req_ready_o, done_o, state_o);
    end
    if (b2b) begin
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_dirty_i = 1'b0;
    victim_addr_i = '0; victim_line_i = '0;
    mem_ready_i = 1'b0; addr_ready_i = 1'b0; mem_data_i = '0; mem_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (req_ready_o !== 1'b1 || state_o !== IDLE || fill_valid_o !== 1'b0 || fill_idx_o !== '0 ||
        fill_data_o !== '0 || done_o !== 1'b0 || wb_valid_o !== 1'b0 || wb_data_o !== '0 ||
        wb_addr_o !== '0 || addr_req_o !== 1'b0 || addr_o !== '0 || mem_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b state=%0d wbv=%b areq=%b mrdy=%b expected 1 0 0 0 0",
               req_ready_o, state_o, wb_valid_o, addr_req_o, mem_ready_o);
    end
  endtask

  task automatic test_clean_miss();
    accept(32'h0000_1040, 1'b0, 32'h0, '0, 1'b0, '0);
    run_miss(0, -1, 1'b0);
  endtask

  task automatic test_dirty_miss();
    cache_line_t line;
    line = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    accept(32'h0000_5000, 1'b1, 32'h0000_2000, line, 1'b0, '0);
    run_miss(0, -1, 1'b0);
  endtask

  task automatic test_stalls();
    cache_line_t line;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < LINE_WORDS; i++) line[i] = $urandom;
      accept($urandom, n[0] | 1'($urandom_range(1)), $urandom, line, 1'b0, '0);
      run_miss(45, -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    accept(32'h0000_1100, 1'b0, 32'h0, '0, 1'b1, 32'h0000_3000);
    run_miss(20, -1, 1'b1);
    load_model(32'h0000_3000, 1'b0, 32'h0, '0);
    run_miss(20, -1, 1'b0);
  endtask

  task automatic test_reset_mid();
    accept(32'h0000_4000, 1'b0, 32'h0, '0, 1'b0, '0);
    run_miss(0, 2, 1'b0);
    accept(32'h0000_4000, 1'b0, 32'h0, '0, 1'b0, '0);
    run_miss(0, -1, 1'b0);
  endtask

  task automatic test_addr_wrap();
    accept(32'hFFFF_FFF3, 1'b0, 32'h0, '0, 1'b0, '0);
    run_miss(0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
